cpu_gpio_pio: RTL and testbench

- Parametrised general-purpose I/O port, the successor to the fixed 32-bit output-only PIO slave on the CPU's Avalon-MM bus.
- Per-bit direction control, synchronised inputs, edge capture and a maskable interrupt.
- Sits on the system interconnect as a zero-wait-state slave.
- Drives board/accelerator control lines and samples status lines, e.g. classifier done/ready flags.

---
 rtl/cpu_gpio_pio_if.sv | 40 ++++
 rtl/cpu_gpio_pio.sv | 169 ++++++++++++++++
 tb/tb_cpu_gpio_pio.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_gpio_pio_if.sv
// ---------------------------------------------------------------------------
// cpu_gpio_pio_if
//   Register-bus bundle for the cpu_gpio_pio slave. The bus is always 32 bits
//   wide regardless of the port WIDTH; unused upper bits are ignored on write
//   and read back as zero.
//
//   Signals:
//     address     3   register select
//     chipselect  1   slave select
//     write_n     1   active-low write strobe (write = chipselect && !write_n)
//     writedata   32  write data
//     readdata    32  combinational read data (zero-wait-state)
//
//   Modports:
//     master  - the CPU / interconnect side
//     slave   - the GPIO block
// ---------------------------------------------------------------------------
interface cpu_gpio_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/cpu_gpio_pio.sv
// ---------------------------------------------------------------------------
// cpu_gpio_pio
//   Parametrised general-purpose I/O port on a zero-wait-state register bus.
//   Per-bit direction, synchronised inputs, edge capture with write-1-to-clear
//   and a maskable, registered interrupt.
//
//   Optional feature (compile-time macro CPU_GPIO_PIO_OUTSETCLR_EN):
//     defined   -> address 4 sets and address 5 clears bits of data_out
//     undefined -> addresses 4 and 5 are reserved like 6 and 7
//
//   Register map:
//     0 data        wr: data_out;  rd: per bit dir ? data_out : in_sync
//     1 direction   R/W, 1 = output
//     2 irqmask     R/W
//     3 edgecapture rd: edgecap;   wr: write-1-to-clear
//     4 outset      wr: data_out |= writedata  (feature only), reads 0
//     5 outclear    wr: data_out &= ~writedata (feature only), reads 0
//     6,7           reserved, read 0
//
//   Ports:
//     clk       system clock, rising edge
//     reset_n   asynchronous active-low reset
//     bus       register bus (slave modport)
//     in_port   external inputs, asynchronous to clk
//     out_port  output data register
//     oe        per-bit output enable (direction register)
//     irq       registered interrupt request
//
//   Parameters: WIDTH (1..32), RESET_VALUE, EDGE_TYPE (0 rise, 1 fall,
//   2 any), IRQ_TYPE (0 level, 1 edge), SYNC_STAGES (2..4).
// ---------------------------------------------------------------------------
module cpu_gpio_pio #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = 0,
    parameter int               IRQ_TYPE    = 1,
    parameter int               SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    cpu_gpio_pio_if.slave     bus,
    input  logic [WIDTH-1:0]  in_port,
    output logic [WIDTH-1:0]  out_port,
    output logic [WIDTH-1:0]  oe,
    output logic              irq
);

`ifdef CPU_GPIO_PIO_OUTSETCLR_EN
    localparam bit SETCLR_EN = 1'b1;
`else
    localparam bit SETCLR_EN = 1'b0;
`endif

    // Arm counter saturates at SYNC_STAGES+1: by then the synchroniser and
    // the previous-sample flop hold real pin values, so reset-state zeros
    // can no longer fake an edge.
    localparam int               ARM_W   = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_MAX = ARM_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] data_out_reg, data_out_next;
    logic [WIDTH-1:0] dir_reg;
    logic [WIDTH-1:0] irqmask_reg;
    logic [WIDTH-1:0] edgecap_reg, edgecap_next;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;
    logic [WIDTH-1:0] in_prev_reg;
    logic [ARM_W-1:0] arm_cnt_reg;
    logic             irq_reg, irq_next;

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] data_rd;
    logic             armed;
    logic [31:0]      rd_word;

    assign wr_en   = bus.chipselect && !bus.write_n;
    assign wdata   = bus.writedata[WIDTH-1:0];
    assign in_sync = sync_reg[SYNC_STAGES-1];
    assign armed   = (arm_cnt_reg == ARM_MAX);

    // Per-bit edge selection and data read-back mux.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic rise, fall;
            assign rise = in_sync[gi] & ~in_prev_reg[gi];
            assign fall = ~in_sync[gi] & in_prev_reg[gi];
            if (EDGE_TYPE == 0) begin : g_rise
                assign edge_evt[gi] = armed & rise;
            end else if (EDGE_TYPE == 1) begin : g_fall
                assign edge_evt[gi] = armed & fall;
            end else begin : g_any
                assign edge_evt[gi] = armed & (rise | fall);
            end
            assign data_rd[gi] = dir_reg[gi] ? data_out_reg[gi] : in_sync[gi];
        end
    endgenerate

    always_comb begin
        data_out_next = data_out_reg;
        if (wr_en) begin
            case (bus.address)
                3'd0: data_out_next = wdata;
                3'd4: if (SETCLR_EN) data_out_next = data_out_reg | wdata;
                3'd5: if (SETCLR_EN) data_out_next = data_out_reg & ~wdata;
                default: ;
            endcase
        end
    end

    // New edges are OR-ed in after the clear so a set on the same cycle wins.
    always_comb begin
        edgecap_next = edgecap_reg;
        if (wr_en && bus.address == 3'd3)
            edgecap_next = edgecap_reg & ~wdata;
        edgecap_next = edgecap_next | edge_evt;
    end

    always_comb begin
        if (IRQ_TYPE == 1)
            irq_next = |(edgecap_reg & irqmask_reg);
        else
            irq_next = |(in_sync & irqmask_reg);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_reg <= RESET_VALUE;
            dir_reg      <= '0;
            irqmask_reg  <= '0;
            edgecap_reg  <= '0;
            sync_reg     <= '0;
            in_prev_reg  <= '0;
            arm_cnt_reg  <= '0;
            irq_reg      <= 1'b0;
        end else begin
            data_out_reg <= data_out_next;
            edgecap_reg  <= edgecap_next;
            sync_reg     <= {sync_reg[SYNC_STAGES-2:0], in_port};
            in_prev_reg  <= in_sync;
            irq_reg      <= irq_next;
            if (!armed)
                arm_cnt_reg <= arm_cnt_reg + ARM_W'(1);
            if (wr_en && bus.address == 3'd1)
                dir_reg <= wdata;
            if (wr_en && bus.address == 3'd2)
                irqmask_reg <= wdata;
        end
    end

    // Zero-latency read: readdata follows address even without chipselect.
    always_comb begin
        rd_word = '0;
        case (bus.address)
            3'd0:    rd_word[WIDTH-1:0] = data_rd;
            3'd1:    rd_word[WIDTH-1:0] = dir_reg;
            3'd2:    rd_word[WIDTH-1:0] = irqmask_reg;
            3'd3:    rd_word[WIDTH-1:0] = edgecap_reg;
            default: rd_word = '0;
        endcase
    end

    assign bus.readdata = rd_word;
    assign out_port     = data_out_reg;
    assign oe           = dir_reg;
    assign irq          = irq_reg;

endmodule

// File: tb/tb_cpu_gpio_pio.sv
// ---------------------------------------------------------------------------
// tb_cpu_gpio_pio
//   Two instances: dut_a (RESET_VALUE=0xA5, rising edge, edge irq) and
//   dut_b (RESET_VALUE=0, any edge, level irq). Expected values are queued
//   on a scoreboard when stimulus is applied and popped on each sample.
// ---------------------------------------------------------------------------
module tb_cpu_gpio_pio;

    localparam int S = 2;

`ifdef CPU_GPIO_PIO_OUTSETCLR_EN
    localparam bit SETCLR = 1'b1;
`else
    localparam bit SETCLR = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [31:0] in_a, in_b;
    logic [31:0] out_a, out_b, oe_a, oe_b;
    logic        irq_a, irq_b;

    cpu_gpio_pio_if bus_a ();
    cpu_gpio_pio_if bus_b ();

    cpu_gpio_pio #(
        .WIDTH(32), .RESET_VALUE(32'h0000_00A5), .EDGE_TYPE(0),
        .IRQ_TYPE(1), .SYNC_STAGES(S)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a),
        .in_port(in_a), .out_port(out_a), .oe(oe_a), .irq(irq_a)
    );

    cpu_gpio_pio #(
        .WIDTH(32), .RESET_VALUE(32'h0), .EDGE_TYPE(2),
        .IRQ_TYPE(0), .SYNC_STAGES(S)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b),
        .in_port(in_b), .out_port(out_b), .oe(oe_b), .irq(irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  addr;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic sb_push(input string n, input logic [31:0] e);
        sb_t s;
        s.name = n;
        s.exp  = e;
        sb_q.push_back(s);
    endtask

    task automatic sb_check(input logic [31:0] act);
        sb_t s;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: got %h, nothing expected", act);
        end else begin
            s = sb_q.pop_front();
            if (act !== s.exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", s.name, act, s.exp);
            end else begin
                $display("ok   %s: %h", s.name, act);
            end
        end
    endtask

    task automatic chk(input string n, input logic [31:0] e, input logic [31:0] a);
        sb_push(n, e);
        sb_check(a);
    endtask

    task automatic bus_idle();
        bus_a.address = 3'd0; bus_a.chipselect = 1'b0;
        bus_a.write_n = 1'b1; bus_a.writedata = 32'h0;
        bus_b.address = 3'd0; bus_b.chipselect = 1'b0;
        bus_b.write_n = 1'b1; bus_b.writedata = 32'h0;
    endtask

    task automatic drive_write(input bit sel, input logic [2:0] a,
                               input logic [31:0] d, input bit cs);
        if (!sel) begin
            bus_a.address = a; bus_a.chipselect = cs;
            bus_a.write_n = 1'b0; bus_a.writedata = d;
        end else begin
            bus_b.address = a; bus_b.chipselect = cs;
            bus_b.write_n = 1'b0; bus_b.writedata = d;
        end
    endtask

    // Write is sampled at the posedge between the two negedges.
    task automatic bus_write(input bit sel, input logic [2:0] a,
                             input logic [31:0] d, input bit cs);
        @(negedge clk);
        drive_write(sel, a, d, cs);
        @(negedge clk);
        bus_idle();
    endtask

    task automatic bus_read(input bit sel, input logic [2:0] a,
                            output logic [31:0] d);
        if (!sel) begin
            bus_a.address = a; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b1;
            #1 d = bus_a.readdata;
        end else begin
            bus_b.address = a; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b1;
            #1 d = bus_b.readdata;
        end
        bus_idle();
    endtask

    task automatic rd_chk(input bit sel, input logic [2:0] a,
                          input logic [31:0] e, input string n);
        logic [31:0] d;
        sb_push(n, e);
        bus_read(sel, a, d);
        sb_check(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t rst_vec[8];
    vec_t cfg_vec[8];

    initial begin
        logic [31:0] rd;

        for (int i = 0; i < 8; i++) begin
            rst_vec[i].name = $sformatf("rst_rd_addr%0d", i);
            rst_vec[i].addr = 3'(i);
            rst_vec[i].exp  = 32'h0;
        end
        cfg_vec[0] = '{"cfg_rd_data",    3'd0, 32'hABCD_EF78};
        cfg_vec[1] = '{"cfg_rd_dir",     3'd1, 32'h0000_00FF};
        cfg_vec[2] = '{"cfg_rd_irqmask", 3'd2, 32'h0000_0000};
        cfg_vec[3] = '{"cfg_rd_edgecap", 3'd3, 32'hABCD_EF00};
        cfg_vec[4] = '{"cfg_rd_outset",  3'd4, 32'h0000_0000};
        cfg_vec[5] = '{"cfg_rd_outclr",  3'd5, 32'h0000_0000};
        cfg_vec[6] = '{"cfg_rd_rsv6",    3'd6, 32'h0000_0000};
        cfg_vec[7] = '{"cfg_rd_rsv7",    3'd7, 32'h0000_0000};

        // ---- reset state ----
        bus_idle();
        in_a = 32'h0;
        in_b = 32'h0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk("rst_out_port", 32'h0000_00A5, out_a);
        chk("rst_oe", 32'h0, oe_a);
        chk("rst_irq", 32'h0, {31'h0, irq_a});
        for (int i = 0; i < 8; i++) begin
            sb_push(rst_vec[i].name, rst_vec[i].exp);
            bus_read(1'b0, rst_vec[i].addr, rd);
            sb_check(rd);
        end

        // ---- direction / data / synchroniser latency ----
        bus_write(1'b0, 3'd1, 32'h0000_00FF, 1'b1);
        bus_write(1'b0, 3'd0, 32'h1234_5678, 1'b1);
        chk("cfg_oe", 32'h0000_00FF, oe_a);
        chk("cfg_out_port", 32'h1234_5678, out_a);
        in_a = 32'hABCD_EF00;
        for (int k = 1; k <= S + 1; k++) begin
            @(negedge clk);
            rd_chk(1'b0, 3'd0, (k >= S) ? 32'hABCD_EF78 : 32'h0000_0078,
                   $sformatf("sync_data_k%0d", k));
            rd_chk(1'b0, 3'd3, (k >= S + 1) ? 32'hABCD_EF00 : 32'h0,
                   $sformatf("sync_edgecap_k%0d", k));
        end
        for (int i = 0; i < 8; i++) begin
            sb_push(cfg_vec[i].name, cfg_vec[i].exp);
            bus_read(1'b0, cfg_vec[i].addr, rd);
            sb_check(rd);
        end

        // ---- ignored writes ----
        bus_write(1'b0, 3'd0, 32'hDEAD_BEEF, 1'b0);
        chk("cs_low_write_ignored", 32'h1234_5678, out_a);
        bus_write(1'b0, 3'd6, 32'hFFFF_FFFF, 1'b1);
        rd_chk(1'b0, 3'd6, 32'h0, "rsv6_after_write");
        chk("rsv6_write_no_effect", 32'h1234_5678, out_a);

        // ---- falling edges not captured in rising mode; W1C ----
        in_a = 32'h0;
        repeat (5) @(negedge clk);
        rd_chk(1'b0, 3'd3, 32'hABCD_EF00, "fall_not_captured");
        bus_write(1'b0, 3'd3, 32'hFFFF_FFFF, 1'b1);
        rd_chk(1'b0, 3'd3, 32'h0, "w1c_all");

        // ---- rising edge latency and edge irq ----
        bus_write(1'b0, 3'd2, 32'h0000_0001, 1'b1);
        @(negedge clk);
        in_a = 32'h1;
        for (int k = 1; k <= S + 2; k++) begin
            @(negedge clk);
            rd_chk(1'b0, 3'd3, (k >= S + 1) ? 32'h1 : 32'h0,
                   $sformatf("edge_lat_k%0d", k));
            chk($sformatf("irq_lat_k%0d", k), (k >= S + 2) ? 32'h1 : 32'h0,
                {31'h0, irq_a});
        end

        // ---- set wins over simultaneous clear ----
        in_a = 32'h0;
        repeat (4) @(negedge clk);
        in_a = 32'h1;
        repeat (S) @(negedge clk);
        drive_write(1'b0, 3'd3, 32'h1, 1'b1);
        @(negedge clk);
        bus_idle();
        rd_chk(1'b0, 3'd3, 32'h1, "set_beats_clear");
        chk("irq_after_collision", 32'h1, {31'h0, irq_a});

        // ---- clear with no edge drops irq one cycle later ----
        bus_write(1'b0, 3'd3, 32'h1, 1'b1);
        rd_chk(1'b0, 3'd3, 32'h0, "w1c_bit0");
        chk("irq_same_cycle", 32'h1, {31'h0, irq_a});
        @(negedge clk);
        chk("irq_after_clear", 32'h0, {31'h0, irq_a});

        // ---- output set / clear ----
        bus_write(1'b0, 3'd0, 32'h0000_000F, 1'b1);
        chk("setclr_base", 32'h0000_000F, out_a);
        bus_write(1'b0, 3'd4, 32'h0000_00F0, 1'b1);
        chk("outset", SETCLR ? 32'h0000_00FF : 32'h0000_000F, out_a);
        bus_write(1'b0, 3'd5, 32'h0000_003C, 1'b1);
        chk("outclr", SETCLR ? 32'h0000_00C3 : 32'h0000_000F, out_a);
        rd_chk(1'b0, 3'd4, 32'h0, "outset_reads0");
        rd_chk(1'b0, 3'd5, 32'h0, "outclr_reads0");

        // ---- level irq on dut_b ----
        bus_write(1'b1, 3'd0, 32'h0000_0055, 1'b1);
        chk("b_out_port", 32'h0000_0055, out_b);
        bus_write(1'b1, 3'd2, 32'h0000_0002, 1'b1);
        @(negedge clk);
        in_b = 32'h2;
        for (int k = 1; k <= S + 1; k++) begin
            @(negedge clk);
            chk($sformatf("b_level_irq_k%0d", k), (k >= S + 1) ? 32'h1 : 32'h0,
                {31'h0, irq_b});
        end

        // ---- asynchronous reset mid-interrupt ----
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        in_a = 32'hFFFF_FFFF;
        in_b = 32'h0;
        #1;
        chk("async_rst_irq_b", 32'h0, {31'h0, irq_b});
        chk("async_rst_out_a", 32'h0000_00A5, out_a);
        chk("async_rst_oe_a", 32'h0, oe_a);
        chk("async_rst_out_b", 32'h0, out_b);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // ---- pin held high through reset produces no capture ----
        repeat (20) @(negedge clk);
        rd_chk(1'b0, 3'd3, 32'h0, "held_high_no_capture");
        rd_chk(1'b0, 3'd0, 32'hFFFF_FFFF, "held_high_data_rd");

        // ---- any-edge mode on dut_b ----
        @(negedge clk);
        in_b = 32'h80;
        repeat (4) @(negedge clk);
        rd_chk(1'b1, 3'd3, 32'h80, "any_rise_bit7");
        bus_write(1'b1, 3'd3, 32'h80, 1'b1);
        rd_chk(1'b1, 3'd3, 32'h0, "any_w1c_bit7");
        in_b = 32'h08;
        repeat (4) @(negedge clk);
        rd_chk(1'b1, 3'd3, 32'h88, "any_edge_bits3_7");
        chk("b_irq_masked_off", 32'h0, {31'h0, irq_b});

        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
